// File: rtl/reg_pkg.sv
// Shared definitions for the register-access protocol: opcodes and the
// responder's register map.
package reg_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10
  } op_t;

  localparam int ADDR_ID       = 0;
  localparam int ADDR_CTRL     = 1;
  localparam int ADDR_STATUS   = 2;
  localparam int ADDR_COUNT    = 3;
  localparam int ADDR_SCRATCH0 = 4;

endpackage

// File: rtl/reg_sat_cnt.sv
// Saturating up-counter with a synchronous clear that outranks the increment.
module reg_sat_cnt #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [DWIDTH-1:0] cnt_o
);

  logic [DWIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_rsp_bank.sv
// Responder side of the register interface: decodes NOP/RD/WR requests and
// implements ID, CTRL, W1C STATUS, saturating COUNT and scratch registers.
module reg_rsp_bank
  import reg_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int ID_VAL = 'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              rd_valid,
  output logic              err,
  input  logic [DWIDTH-1:0] hw_event,
  input  logic              cnt_inc,
  output logic [DWIDTH-1:0] ctrl,
  output logic              irq
);

  localparam int NSCR = DEPTH - ADDR_SCRATCH0;
  localparam logic [DWIDTH-1:0] ID_W     = DWIDTH'(ID_VAL);
  localparam logic [AWIDTH-1:0] A_ID     = AWIDTH'(ADDR_ID);
  localparam logic [AWIDTH-1:0] A_CTRL   = AWIDTH'(ADDR_CTRL);
  localparam logic [AWIDTH-1:0] A_STATUS = AWIDTH'(ADDR_STATUS);
  localparam logic [AWIDTH-1:0] A_COUNT  = AWIDTH'(ADDR_COUNT);

  logic              is_rd, is_wr, is_ill, in_range, wr_en;
  logic [DWIDTH-1:0] ctrl_q, ctrl_d;
  logic [DWIDTH-1:0] status_q, status_d;
  logic [DWIDTH-1:0] scratch_q [NSCR];
  logic [DWIDTH-1:0] scratch_d [NSCR];
  logic [DWIDTH-1:0] count;
  logic [DWIDTH-1:0] rd_val;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  assign is_rd    = (op == OP_RD);
  assign is_wr    = (op == OP_WR);
  assign is_ill   = (op == 2'b11);
  assign in_range = ({1'b0, addr} < (AWIDTH+1)'(DEPTH));
  assign wr_en    = is_wr && in_range;

  reg_sat_cnt #(.DWIDTH(DWIDTH)) u_count (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (wr_en && addr == A_COUNT),
    .cnt_o (count)
  );

  // Read mux sees only flop outputs, so a read returns pre-update contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_val = '0;
    if (addr == A_ID)     rd_val = ID_W;
    if (addr == A_CTRL)   rd_val = ctrl_q;
    if (addr == A_STATUS) rd_val = status_q;
    if (addr == A_COUNT)  rd_val = count;
    for (int i = 0; i < NSCR; i++)
      if (addr == AWIDTH'(ADDR_SCRATCH0 + i)) rd_val = scratch_q[i];
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    rdata_d    = rdata_q;
    rd_valid_d = is_rd;
    err_d      = is_ill || ((is_rd || is_wr) && !in_range);
    if (wr_en && addr == A_CTRL) ctrl_d = wdata;
    for (int i = 0; i < NSCR; i++)
      if (wr_en && addr == AWIDTH'(ADDR_SCRATCH0 + i)) scratch_d[i] = wdata;
    // Set is OR-ed in after the clear, so hardware events beat software W1C.
    status_d = (status_q & ~((wr_en && addr == A_STATUS) ? wdata : '0)) | hw_event;
    if (is_rd) rdata_d = rd_val;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    if (rst) begin
      ctrl_q     <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: scratch is a handful of flops with a defined reset value, so it is cleared here rather than left as RAM.
      for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      scratch_q  <= scratch_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign ctrl     = ctrl_q;
  assign irq      = |(status_q & ctrl_q);

endmodule
